// File: rtl/alu_16_bist.sv
// Built-in self-test controller for alu_16: LFSR vector source, MISR response compactor.
// Optional ALU_BIST_FAULT_INJ_EN adds a fault_inj input that flips response bit 0 during RUN.
module alu_16_bist #(
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [33:0] SEED        = 34'h0AA5555AA,
  parameter logic [16:0] GOLDEN_SIG  = 17'h00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [1:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_o,
  input  logic        alu_c_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [16:0] signature
`ifdef ALU_BIST_FAULT_INJ_EN
  ,
  input  logic        fault_inj
`endif
);

  localparam int unsigned CW = $clog2(NUM_VECTORS + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_VECTORS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [33:0]   vec;
  logic [16:0]   misr;
  logic [CW-1:0] count;
  logic [16:0]   resp;

  always_comb begin
`ifdef ALU_BIST_FAULT_INJ_EN
    resp = {alu_c_out, alu_o} ^ {16'b0, fault_inj};
`else
    resp = {alu_c_out, alu_o};
`endif
  end

  // The vector register doubles as the LFSR state, so the ALU inputs are always registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      vec   <= '0;
      misr  <= '0;
      count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            vec   <= SEED;
            misr  <= '0;
            count <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          misr  <= {misr[15:0], misr[16] ^ misr[13]} ^ resp;
          vec   <= {vec[32:0], vec[33] ^ vec[26] ^ vec[1] ^ vec[0]};
          count <= count + 1'b1;
          if (count == LAST) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign {alu_op, alu_a, alu_b} = vec;
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign pass      = done && (misr == GOLDEN_SIG);
  assign signature = misr;

endmodule

// File: tb/tb_alu_16_bist.sv
// Scoreboard bench for alu_16_bist with a behavioural stand-in for alu_16.
// Define ALU_BIST_FAULT_INJ_EN to also exercise the fault_inj port.
module tb_alu_16_bist;

  localparam int unsigned NV   = 20;
  localparam logic [33:0] SEED = 34'h0AA5555AA;
  localparam logic [33:0] TAPS = 34'h204000003;  // x^34 + x^27 + x^2 + x + 1

  function automatic logic [33:0] lfsr_step(input logic [33:0] s);
    return {s[32:0], ^(s & TAPS)};
  endfunction

  function automatic logic [16:0] alu_ref(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, a} - {1'b0, b};
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  function automatic logic [16:0] model_sig(input int n, input int p1, input logic [16:0] m1,
                                             input int p2, input logic [16:0] m2);
    logic [33:0] s;
    logic [16:0] m;
    logic [16:0] r;
    s = SEED;
    m = '0;
    for (int i = 0; i < n; i++) begin
      r = alu_ref(s[33:32], s[31:16], s[15:0]);
      if (i == p1) r = r ^ m1;
      if (i == p2) r = r ^ m2;
      m = {m[15:0], m[16] ^ m[13]} ^ r;
      s = lfsr_step(s);
    end
    return m;
  endfunction

  localparam logic [16:0] GOLDEN = model_sig(NV, -1, 17'h0, -1, 17'h0);

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_o;
  logic        alu_c_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [16:0] signature;

  int          cyc = 0;
  int          start_cyc = 0;
  int          idx;
  logic        err_en = 1'b0;
  int          err_pos = -1;
  logic [16:0] err_mask = '0;
  logic [16:0] rsp;

  logic [33:0] vec_q[$];
  logic [17:0] res_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

`ifdef ALU_BIST_FAULT_INJ_EN
  logic fault_inj;
  logic fi_en = 1'b0;
  int   fi_pos = -1;
  always_comb fault_inj = fi_en && (idx == fi_pos);
`endif

  alu_16_bist #(
    .NUM_VECTORS(NV),
    .SEED(SEED),
    .GOLDEN_SIG(GOLDEN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .alu_op(alu_op),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_o(alu_o),
    .alu_c_out(alu_c_out),
    .busy(busy),
    .done(done),
    .pass(pass),
    .signature(signature)
`ifdef ALU_BIST_FAULT_INJ_EN
    ,
    .fault_inj(fault_inj)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench ALU; optionally corrupts the response to one vector of the run.
  always_comb begin
    idx = cyc - start_cyc;
    rsp = alu_ref(alu_op, alu_a, alu_b);
    if (err_en && idx == err_pos) rsp = rsp ^ err_mask;
  end
  assign {alu_c_out, alu_o} = rsp;

  task automatic check(input string name, input logic [33:0] got, input logic [33:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: consumes expected vectors while busy, expected signature/pass while done.
  initial begin
    logic [17:0] hold;
    int          bcnt;
    logic        done_q;
    hold   = '0;
    bcnt   = 0;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!busy && !done) begin
        vec_q.delete();
        res_q.delete();
        bcnt = 0;
      end else if (busy) begin
        bcnt++;
        if (done) fail("busy_and_done");
        if (vec_q.size() == 0) fail("unexpected_vector");
        else check("vector", {alu_op, alu_a, alu_b}, vec_q.pop_front());
      end else begin
        if (!done_q) begin
          check("latency", 34'(bcnt), 34'(NV));
          bcnt = 0;
          if (res_q.size() == 0) fail("unexpected_done");
          else hold = res_q.pop_front();
        end
        check("signature", 34'(signature), 34'(hold[16:0]));
        check("pass", 34'(pass), 34'(hold[17]));
      end
      done_q = done;
    end
  end

  task automatic push_vectors();
    logic [33:0] s;
    s = SEED;
    for (int i = 0; i < NV; i++) begin
      vec_q.push_back(s);
      s = lfsr_step(s);
    end
  endtask

  task automatic run(input logic e_en, input int e_pos, input logic [16:0] e_mask,
                     input int fpos, input logic extra);
    logic [16:0] sig;
    int          w;
    @(negedge clk);
    err_en   = e_en;
    err_pos  = e_pos;
    err_mask = e_mask;
`ifdef ALU_BIST_FAULT_INJ_EN
    fi_pos = fpos;
    fi_en  = (fpos >= 0);
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start     = 1'b0;
    check("first_vec", {alu_op, alu_a, alu_b}, SEED);
    check("busy_on", 34'({busy, done}), 34'(2'b10));
    push_vectors();
    sig = model_sig(NV, e_en ? e_pos : -1, e_mask, fpos, 17'h1);
    res_q.push_back({sig == GOLDEN, sig});
    if (extra) begin
      repeat ($urandom_range(1, NV - 4)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    w = 0;
    while (!done && w < int'(NV) + 10) begin
      @(negedge clk);
      w++;
    end
    if (!done) fail("done_timeout");
    err_en = 1'b0;
`ifdef ALU_BIST_FAULT_INJ_EN
    fi_en = 1'b0;
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    #3;
    check("reset_vec", {alu_op, alu_a, alu_b}, '0);
    check("reset_flags", 34'({busy, done, pass, signature}), '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_vec", {alu_op, alu_a, alu_b}, '0);
    check("idle_flags", 34'({busy, done, pass, signature}), '0);

    // Clean run, then hold in DONE; rerun from DONE with a start pulse during RUN.
    run(1'b0, -1, '0, -1, 1'b0);
    repeat (20) @(negedge clk);
    run(1'b0, -1, '0, -1, 1'b1);
    repeat (3) @(negedge clk);

    // Abort at cycle 2 of a run.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    push_vectors();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_vec", {alu_op, alu_a, alu_b}, '0);
    check("abort_flags", 34'({busy, done, pass, signature}), '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NV + 5) @(negedge clk);
    check("abort_no_done", 34'({busy, done}), '0);

`ifdef ALU_BIST_FAULT_INJ_EN
    run(1'b0, -1, '0, 5, 1'b0);
    check("fault_pass", 34'({done, pass}), 34'(2'b10));
`endif

    for (int r = 0; r < 8; r++) begin
      int fp;
      fp = -1;
`ifdef ALU_BIST_FAULT_INJ_EN
      if ($urandom_range(0, 3) == 0) fp = int'($urandom_range(0, NV - 1));
`endif
      run(1'($urandom_range(0, 1)), int'($urandom_range(0, NV - 1)),
          17'($urandom_range(1, 17'h1FFFF)), fp, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 5)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
